// File: rtl/shift_normalizer.sv
// shift_normalizer: multi-cycle CLZ/CLS normalizer with valid/ready handshakes on both sides.
// Define SHIFT_NORMALIZER_FAST_EN to allow 8-bit strides in RUN (identical results, lower latency).
//
// state | meaning
// IDLE  | accepting an operand
// RUN   | shifting until normalized or the count limit is reached
// DONE  | result held until out_ready
module shift_normalizer #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_norm,
  output logic [CNT_W-1:0] out_count,
  output logic             out_zero
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] sh;
  logic [CNT_W-1:0] cnt;
  logic             mode_q;
  logic             zero_q;
  logic             zero_in;
  logic             term;
  logic             stride;

  assign zero_in = (in_data == '0) || (in_mode && (in_data == '1));

  // Sign mode stops one short of the width: the sign bit itself is never shifted out.
  always_comb begin
    if (mode_q)
      term = (sh[WIDTH-1] != sh[WIDTH-2]) || (cnt == CNT_W'(WIDTH-1));
    else
      term = sh[WIDTH-1] || (cnt == CNT_W'(WIDTH));
  end

`ifdef SHIFT_NORMALIZER_FAST_EN
  always_comb begin
    if (mode_q)
      stride = ((sh[WIDTH-1 -: 9] == '0) || (sh[WIDTH-1 -: 9] == '1)) &&
               (cnt <= CNT_W'(WIDTH-9));
    else
      stride = (sh[WIDTH-1 -: 8] == '0) && (cnt <= CNT_W'(WIDTH-8));
  end
`else
  assign stride = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid) state_nxt = RUN;
      RUN:     if (term) state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state == IDLE);
    out_valid = (state == DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sh        <= '0;
      cnt       <= '0;
      mode_q    <= 1'b0;
      zero_q    <= 1'b0;
      out_norm  <= '0;
      out_count <= '0;
      out_zero  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            sh     <= in_data;
            cnt    <= '0;
            mode_q <= in_mode;
            zero_q <= zero_in;
          end
        end
        RUN: begin
          if (term) begin
            out_norm  <= sh;
            out_count <= cnt;
            out_zero  <= zero_q;
          end else if (stride) begin
            sh  <= sh << 8;
            cnt <= cnt + CNT_W'(8);
          end else begin
            sh  <= sh << 1;
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule
